// File: rtl/pio_pkg.sv
// pio_pkg: shared CC stream beat type and interface constants for the PIO completer path
package pio_pkg;
  localparam int CC_DATA_WIDTH   = 64;
  localparam int CC_KEEP_WIDTH   = CC_DATA_WIDTH / 32;
  localparam int CC_TUSER_WIDTH  = 33;
  localparam int CC_TREADY_WIDTH = 4;
  typedef struct packed {
    logic [CC_DATA_WIDTH-1:0]  tdata;
    logic [CC_KEEP_WIDTH-1:0]  tkeep;
    logic [CC_TUSER_WIDTH-1:0] tuser;
    logic                      tlast;
  } cc_beat_t;
endpackage

// File: rtl/pio_sync_fifo.sv
// pio_sync_fifo: single-clock circular RAM FIFO with show-ahead read
//   clk/rst_n  clock, async active-low reset
//   i_push     write i_data at the tail (caller guarantees not full)
//   i_pop      advance the head (caller guarantees not empty)
//   o_data     current head entry, o_empty, o_count entries stored
module pio_sync_fifo #(
  parameter int W     = 100,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic [AW:0]  o_count
);
  logic [W-1:0]  r_ram [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  always_ff @(posedge clk)
    if (i_push) r_ram[r_wr] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= r_wr + AW'(i_push);
      r_rd  <= r_rd + AW'(i_pop);
      r_cnt <= r_cnt + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  assign o_data  = r_ram[r_rd];
  assign o_empty = ~|r_cnt;
  assign o_count = r_cnt;
endmodule

// File: rtl/pio_cc_buffer.sv
// pio_cc_buffer: CC AXI-Stream buffer between host_pio and the PCIe core s_axis_cc port
//   user_clk/reset_n  sole clock, asynchronous active-low reset
//   in_*              CC beats from host_pio; in_tready decoded from registered state only
//   s_axis_cc_*       CC beats to the core from a registered first-word-fall-through stage
//   level, pkt_cnt    beats stored (incl. output register), complete TLPs not yet drained
//   oversize          only with PIO_CC_STORE_FWD_EN defined: sticky deadlock-escape flag
module pio_cc_buffer
  import pio_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int TUSER_WIDTH  = CC_TUSER_WIDTH,
  parameter int DEPTH        = 16,
  parameter int AW           = $clog2(DEPTH)
) (
  input  logic                       user_clk,
  input  logic                       reset_n,
  input  logic [C_DATA_WIDTH-1:0]    in_tdata,
  input  logic [TUSER_WIDTH-1:0]     in_tuser,
  input  logic                       in_tlast,
  input  logic [KEEP_WIDTH-1:0]      in_tkeep,
  input  logic                       in_tvalid,
  output logic                       in_tready,
  output logic [C_DATA_WIDTH-1:0]    s_axis_cc_tdata,
  output logic [TUSER_WIDTH-1:0]     s_axis_cc_tuser,
  output logic                       s_axis_cc_tlast,
  output logic [KEEP_WIDTH-1:0]      s_axis_cc_tkeep,
  output logic                       s_axis_cc_tvalid,
  input  logic [CC_TREADY_WIDTH-1:0] s_axis_cc_tready,
  output logic [AW:0]                level,
  output logic [AW:0]                pkt_cnt
`ifdef PIO_CC_STORE_FWD_EN
  ,
  output logic                       oversize
`endif
);
  localparam int W = C_DATA_WIDTH + KEEP_WIDTH + TUSER_WIDTH + 1;
  logic          r_init, r_valid;
  logic [W-1:0]  r_beat, w_head;
  logic [AW:0]   r_pkt, w_fcnt;
  logic          w_empty, w_push, w_pop, w_load, w_gate, w_unused;
  assign w_unused = ^s_axis_cc_tready[CC_TREADY_WIDTH-1:1];
  assign w_push   = in_tvalid & in_tready;
  assign w_pop    = r_valid & s_axis_cc_tready[0];
  // refill the output register whenever it is empty or being drained this cycle
  assign w_load   = ~w_empty & (~r_valid | w_pop) & w_gate;
  assign level    = w_fcnt + {{AW{1'b0}}, r_valid};
  // level never exceeds DEPTH (a power of two), so its MSB alone flags full
  assign in_tready = r_init & ~level[AW];
  pio_sync_fifo #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk     (user_clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  ({in_tdata, in_tkeep, in_tuser, in_tlast}),
    .i_pop   (w_load),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_fcnt)
  );
  always_ff @(posedge user_clk or negedge reset_n)
    if (!reset_n) begin
      r_init  <= 1'b0;
      r_valid <= 1'b0;
      r_beat  <= '0;
      r_pkt   <= '0;
    end else begin
      r_init  <= 1'b1;
      r_valid <= w_load | (r_valid & ~w_pop);
      if (w_load) r_beat <= w_head;
      r_pkt   <= r_pkt + {{AW{1'b0}}, w_push & in_tlast} - {{AW{1'b0}}, w_pop & s_axis_cc_tlast};
    end
`ifdef PIO_CC_STORE_FWD_EN
  logic        r_mid, r_oversize, w_esc;
  logic [AW:0] w_fpkt;
  // complete TLPs still waiting behind the output register
  assign w_fpkt   = r_pkt - {{AW{1'b0}}, r_valid & r_beat[0]};
  // full with no tlast stored: this TLP can never complete here, so let it cut through
  assign w_esc    = level[AW] & ~|r_pkt;
  assign w_gate   = r_mid | (|w_fpkt) | w_esc;
  assign oversize = r_oversize;
  always_ff @(posedge user_clk or negedge reset_n)
    if (!reset_n) begin
      r_mid      <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      if (w_load) r_mid <= ~w_head[0];
      if (w_esc) r_oversize <= 1'b1;
    end
`else
  assign w_gate = 1'b1;
`endif
  assign {s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tuser, s_axis_cc_tlast} = r_beat;
  assign s_axis_cc_tvalid = r_valid;
  assign pkt_cnt          = r_pkt;
endmodule

// File: tb/tb_pio_cc_buffer.sv
// tb_pio_cc_buffer: vector table, directed corner cases and a queue-model random run
module tb_pio_cc_buffer;
  import pio_pkg::*;
  localparam int DW = 64, KW = 2, TW = CC_TUSER_WIDTH, DEPTH = 16, AW = 4;
  logic            user_clk = 0, reset_n = 1;
  logic [DW-1:0]   in_tdata = '0;
  logic [TW-1:0]   in_tuser = '0;
  logic            in_tlast = 0, in_tvalid = 0, in_tready;
  logic [KW-1:0]   in_tkeep = '0;
  logic [DW-1:0]   s_axis_cc_tdata;
  logic [TW-1:0]   s_axis_cc_tuser;
  logic            s_axis_cc_tlast, s_axis_cc_tvalid;
  logic [KW-1:0]   s_axis_cc_tkeep;
  logic [3:0]      s_axis_cc_tready = '0;
  logic [AW:0]     level, pkt_cnt;
`ifdef PIO_CC_STORE_FWD_EN
  logic            oversize;
`endif
  pio_cc_buffer #(.C_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TUSER_WIDTH(TW), .DEPTH(DEPTH), .AW(AW)) dut (
    .user_clk         (user_clk),
    .reset_n          (reset_n),
    .in_tdata         (in_tdata),
    .in_tuser         (in_tuser),
    .in_tlast         (in_tlast),
    .in_tkeep         (in_tkeep),
    .in_tvalid        (in_tvalid),
    .in_tready        (in_tready),
    .s_axis_cc_tdata  (s_axis_cc_tdata),
    .s_axis_cc_tuser  (s_axis_cc_tuser),
    .s_axis_cc_tlast  (s_axis_cc_tlast),
    .s_axis_cc_tkeep  (s_axis_cc_tkeep),
    .s_axis_cc_tvalid (s_axis_cc_tvalid),
    .s_axis_cc_tready (s_axis_cc_tready),
    .level            (level),
    .pkt_cnt          (pkt_cnt)
`ifdef PIO_CC_STORE_FWD_EN
    ,
    .oversize         (oversize)
`endif
  );
  always #5 user_clk = ~user_clk;
  typedef struct {
    cc_beat_t b;
    int       stamp;
  } ent_t;
  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        l;
    logic [3:0]  r;
    logic        etv;
    logic        erdy;
    int          elev;
    int          epkt;
    logic [63:0] ed;
  } vec_t;
  ent_t q[$];
  int   n_vec = 0, n_bad = 0, cyc = 0, npop = 0;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic tick;
    @(posedge user_clk);
    #1;
    cyc++;
  endtask
  task automatic put(input logic v, input logic [63:0] d, input logic l, input logic [3:0] r);
    in_tvalid = v;
    in_tdata = d;
    in_tlast = l;
    in_tkeep = 2'b11;
    in_tuser = '0;
    s_axis_cc_tready = r;
  endtask
  task automatic do_reset;
    reset_n = 0;
    in_tvalid = 0;
    s_axis_cc_tready = '0;
    #1;
    chk("rst_tvalid", s_axis_cc_tvalid, 0);
    chk("rst_level", level, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_in_tready", in_tready, 0);
    chk("rst_tdata", s_axis_cc_tdata, 0);
    q.delete();
    repeat (5) tick;
    reset_n = 1;
    #1;
    chk("rel_in_tready", in_tready, 0);
    tick;
    chk("init_in_tready", in_tready, 1);
  endtask
  // model: q holds every stored beat in order; the head is visible one edge after its push
  task automatic rstep(input logic v, input logic [3:0] r, input int lm, output logic acc);
    cc_beat_t b;
    logic     pop;
    int       np;
    np = 0;
    foreach (q[i]) np += int'(q[i].b.tlast);
    chk("level", level, q.size());
    chk("pkt_cnt", pkt_cnt, np);
    chk("in_tready", in_tready, q.size() < DEPTH);
`ifndef PIO_CC_STORE_FWD_EN
    chk("tvalid", s_axis_cc_tvalid, q.size() > 0 && q[0].stamp < cyc);
`endif
    if (s_axis_cc_tvalid) begin
      if (q.size() == 0) chk("tvalid_empty", s_axis_cc_tvalid, 0);
      else chk("beat", {s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tuser, s_axis_cc_tlast}, q[0].b);
    end
    b.tdata = {$urandom, $urandom};
    b.tkeep = 2'($urandom);
    b.tuser = {1'($urandom), $urandom};
    b.tlast = lm == 1 ? 1'b1 : lm == 2 ? 1'b0 : $urandom_range(0, 3) == 0;
    acc = v && q.size() < DEPTH;
    pop = s_axis_cc_tvalid && r[0] && q.size() > 0;
    in_tvalid = v;
    {in_tdata, in_tkeep, in_tuser, in_tlast} = b;
    s_axis_cc_tready = r;
    tick;
    if (pop) begin
      void'(q.pop_front());
      npop++;
    end
    if (acc) q.push_back('{b, cyc});
  endtask
  initial begin
    #20000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t vt[8];
    logic acc;
    int   sent, got;
    vt[0] = '{1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 4'h0, 1'b0, 1'b1, 1, 1, 64'h0};
    vt[1] = '{1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1, 1, 64'hDEAD_BEEF_0000_0001};
    vt[2] = '{1'b0, 64'h0, 1'b0, 4'hE, 1'b1, 1'b1, 1, 1, 64'hDEAD_BEEF_0000_0001};
    vt[3] = '{1'b0, 64'h0, 1'b0, 4'h1, 1'b0, 1'b1, 0, 0, 64'h0};
    vt[4] = '{1'b1, 64'hA5A5_0000_0000_0004, 1'b1, 4'h1, 1'b0, 1'b1, 1, 1, 64'h0};
    vt[5] = '{1'b1, 64'h5A5A_0000_0000_0005, 1'b1, 4'h1, 1'b1, 1'b1, 2, 2, 64'hA5A5_0000_0000_0004};
    vt[6] = '{1'b0, 64'h0, 1'b0, 4'h1, 1'b1, 1'b1, 1, 1, 64'h5A5A_0000_0000_0005};
    vt[7] = '{1'b0, 64'h0, 1'b0, 4'h1, 1'b0, 1'b1, 0, 0, 64'h0};
    #2;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      put(vt[i].v, vt[i].d, vt[i].l, vt[i].r);
      tick;
      chk($sformatf("vec%0d_tvalid", i), s_axis_cc_tvalid, vt[i].etv);
      chk($sformatf("vec%0d_in_tready", i), in_tready, vt[i].erdy);
      chk($sformatf("vec%0d_level", i), level, vt[i].elev);
      chk($sformatf("vec%0d_pkt_cnt", i), pkt_cnt, vt[i].epkt);
      if (vt[i].etv) chk($sformatf("vec%0d_tdata", i), s_axis_cc_tdata, vt[i].ed);
    end
    // backpressure: fill to DEPTH, pop at full must not admit a push, then drain in order
    for (int i = 0; i < 16; i++) begin
      put(1, 64'h1000 + 64'(i), 1, 4'h0);
      tick;
    end
    chk("full_level", level, 16);
    chk("full_in_tready", in_tready, 0);
    chk("full_pkt_cnt", pkt_cnt, 16);
    chk("full_tvalid", s_axis_cc_tvalid, 1);
    chk("full_tdata", s_axis_cc_tdata, 64'h1000);
    put(1, 64'hBAD, 1, 4'hF);
    tick;
    chk("fullpop_level", level, 15);
    chk("fullpop_in_tready", in_tready, 1);
    put(0, 0, 0, 4'hF);
    for (int i = 1; i < 16; i++) begin
      chk("drain_tvalid", s_axis_cc_tvalid, 1);
      chk("drain_tdata", s_axis_cc_tdata, 64'h1000 + 64'(i));
      tick;
    end
    chk("drained_tvalid", s_axis_cc_tvalid, 0);
    chk("drained_level", level, 0);
    chk("drained_pkt_cnt", pkt_cnt, 0);
    // random traffic around a half-full buffer
    q.delete();
    for (int i = 0; i < 8; i++) rstep(1, 4'h0, 0, acc);
    for (int i = 0; i < 1000; i++) rstep(1'($urandom_range(0, 1)), 4'($urandom), 0, acc);
    for (int k = 0; k < 64; k++) begin
      rstep(1, 4'h1, 1, acc);
      if (acc) break;
    end
    for (int k = 0; k < 64 && q.size() > 0; k++) rstep(0, 4'h1, 0, acc);
    chk("rand_empty_level", level, 0);
    // reset in the middle of a 5-beat TLP, then a clean TLP
    for (int i = 0; i < 3; i++) rstep(1, 4'h0, 2, acc);
    do_reset;
    npop = 0;
    for (int i = 0; i < 4; i++) rstep(1, 4'h1, 2, acc);
    rstep(1, 4'h1, 1, acc);
    for (int k = 0; k < 64 && q.size() > 0; k++) rstep(0, 4'h1, 0, acc);
    chk("post_reset_pops", npop, 5);
    chk("post_reset_level", level, 0);
`ifdef PIO_CC_STORE_FWD_EN
    // held until tlast is stored, then sent back-to-back
    put(1, 64'h3000, 0, 4'hF);
    tick;
    chk("sf_hold0", s_axis_cc_tvalid, 0);
    put(1, 64'h3001, 0, 4'hF);
    tick;
    chk("sf_hold1", s_axis_cc_tvalid, 0);
    put(0, 0, 0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("sf_gap", s_axis_cc_tvalid, 0);
    end
    put(1, 64'h3002, 1, 4'hF);
    tick;
    chk("sf_stored", s_axis_cc_tvalid, 0);
    put(0, 0, 0, 4'hF);
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("sf_burst_tvalid", s_axis_cc_tvalid, 1);
      chk("sf_burst_tdata", s_axis_cc_tdata, 64'h3000 + 64'(i));
      tick;
    end
    chk("sf_done_tvalid", s_axis_cc_tvalid, 0);
    chk("sf_done_pkt_cnt", pkt_cnt, 0);
    chk("sf_oversize_clear", oversize, 0);
    // TLP longer than the buffer escapes in cut-through fashion
    sent = 0;
    got = 0;
    for (int k = 0; k < 200 && got < 20; k++) begin
      put(sent < 20, 64'h4000 + 64'(sent), sent == 19, 4'hF);
      acc = in_tvalid && in_tready;
      if (s_axis_cc_tvalid) begin
        chk("sf20_order", s_axis_cc_tdata, 64'h4000 + 64'(got));
        got++;
      end
      tick;
      if (acc) sent++;
    end
    chk("sf20_count", got, 20);
    chk("sf20_oversize", oversize, 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pio_cc_buffer.md
Name: pio_cc_buffer

Overview:
- Completer-completion (CC) output buffer that sits directly downstream of host_pio.
- Accepts CC AXI-Stream beats from host_pio and presents them to the PCIe core's s_axis_cc interface.
- Decouples host_pio from core back-pressure and cuts the combinational tready path.
- Optionally holds completions until the whole TLP is stored (store-and-forward).

Parameters:
- C_DATA_WIDTH, 64, tdata width in bits.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width (one bit per dword).
- TUSER_WIDTH, 33, CC tuser width.
- DEPTH, 16, beat entries; power of two, minimum 4.
- AW, $clog2(DEPTH), pointer width.

Ports:
- user_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- in_tdata  in  C_DATA_WIDTH  CC data from host_pio.
- in_tuser  in  TUSER_WIDTH  CC tuser from host_pio.
- in_tlast  in  1  last beat of the TLP.
- in_tkeep  in  KEEP_WIDTH  dword enables.
- in_tvalid  in  1  beat valid.
- in_tready  out  1  buffer can accept a beat.
- s_axis_cc_tdata  out  C_DATA_WIDTH  to the PCIe core.
- s_axis_cc_tuser  out  TUSER_WIDTH  to the PCIe core.
- s_axis_cc_tlast  out  1  to the PCIe core.
- s_axis_cc_tkeep  out  KEEP_WIDTH  to the PCIe core.
- s_axis_cc_tvalid  out  1  to the PCIe core.
- s_axis_cc_tready  in  4  core ready; only bit 0 is used, bits 3:1 are ignored.
- level  out  AW+1  beats currently stored, including the output register.
- pkt_cnt  out  AW+1  complete TLPs (tlast seen) not yet fully drained.

Behaviour:
- Reset (reset_n low, asynchronous) clears pointers, level, pkt_cnt and all valid flags.
  - Resulting output values: s_axis_cc_tvalid=0, in_tready=0, level=0, pkt_cnt=0; s_axis_cc data fields = 0.
  - in_tready rises on the first user_clk edge after reset_n deasserts.
- Reset mid-packet discards all buffered beats, including partial TLPs. No recovery of partial TLPs.
- Storage: circular RAM of DEPTH entries, each {tdata, tkeep, tuser, tlast}, plus one output register (first-word-fall-through).
- Input side:
  - Push when in_tvalid && in_tready.
  - in_tready = (level < DEPTH), decoded from registered state only. It never combinationally depends on s_axis_cc_tready.
- Output side:
  - Pop when s_axis_cc_tvalid && s_axis_cc_tready[0].
  - Once tvalid is high, the output register holds stable data and tvalid until the pop occurs.
- Latency: a beat pushed at edge N into an empty buffer drives s_axis_cc_tvalid=1 after edge N+1 (cut-through mode).
- Throughput: one beat per cycle sustained when tready[0] stays high.
- Simultaneous push and pop: level unchanged; order preserved.
- Full (level==DEPTH): in_tready=0. A pop in that cycle does not allow a same-cycle push; in_tready returns to 1 on the following cycle.
- Empty: s_axis_cc_tvalid=0. A push into an empty buffer is not bypassed combinationally.
- Wrap-around: pointers wrap modulo DEPTH. level is the arithmetic count, not a pointer difference.
- pkt_cnt:
  - +1 when a beat with in_tlast=1 is pushed.
  - -1 when a beat with tlast=1 is popped.
  - Both in the same cycle: unchanged.
- Data is passed unmodified; no TLP header inspection.

Optional Feature:
- Macro: PIO_CC_STORE_FWD_EN.
- Defined:
  - s_axis_cc_tvalid is asserted only when pkt_cnt>0, or while a TLP is already in flight (first beat popped, tlast not yet popped). A TLP is never split by idle cycles caused by the buffer.
  - Deadlock escape: if level==DEPTH and pkt_cnt==0, the partial TLP is released in cut-through fashion.
  - Extra output oversize (1 bit) is set sticky on that escape and cleared only by reset.
- Undefined: pure cut-through as described above; the oversize port does not exist.

Decomposition:
- Shared package pio_pkg:
  - CC beat struct typedef {tdata, tkeep, tuser, tlast}.
  - CC_TUSER_WIDTH=33 and CC_TREADY_WIDTH=4 constants.
- One natural sub-module: pio_sync_fifo.
  - Contents: RAM, pointers and level.
  - pio_cc_buffer keeps the output register, pkt_cnt and the store-and-forward gating.

Test Plan:
- Reset/latency: assert reset_n=0 for 5 cycles then release → tvalid=0, level=0, in_tready=1 after the first edge. Push one beat with tdata=64'hDEAD_BEEF_0000_0001, tlast=1 → tvalid=1 exactly one cycle later, data identical, pkt_cnt=1.
- Backpressure: tready=4'h0, push 16 beats → in_tready=0 at level=16. Then tready=4'hF → 16 beats out in order, one per cycle, pkt_cnt returns to 0.
- Ignored tready bits: tready=4'hE → no pop occurs.
- Simultaneous push/pop at level=8 with random valid/ready over 1000 cycles → scoreboard ordering exact, level never exceeds 16, no data loss.
- Reset mid-packet: reset_n=0 after 3 of a 5-beat TLP → level=0, tvalid=0. The next TLP is output intact.
- PIO_CC_STORE_FWD_EN, 3-beat TLP with a 4-cycle gap before the last beat → tvalid stays 0 until tlast is stored, then the 3 beats go out back-to-back.
- PIO_CC_STORE_FWD_EN, 20-beat TLP with DEPTH=16 → oversize=1 and all 20 beats delivered in order.
